hazard_sequencer: RTL and testbench

Pipeline control sequencer for the 5-stage LC-3b datapath (IF, ID, EX, MEM, WB).
- Drives per-stage register loads (load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB).
- Selects the NOP control word into ID/EX and EX/MEM to create bubbles and flushes.
- Resolves memory-wait stalls, taken-branch flushes (resolved in MEM) and load-use bubbles.
- Sits beside the stage registers and is the only block that drives their load/flush controls.

---
 rtl/hazard_sequencer.sv | 143 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline load/flush/bubble control for the 5-stage LC-3b datapath.
// Latency: outputs are combinational from state + inputs (zero cycles); the state register updates on clk.
// Backpressure: a memory wait freezes every stage register; branch flushes beat load-use bubbles.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating performance counters).
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic [2:0]       ex_dr,
  input  logic             ex_is_load,
  input  logic             mem_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             nop_id_ex,
  output logic             flush_if_id,
  output logic             flush_ex_mem,
  output logic             stall,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_flushes
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic mem_wait;
  logic hazard;

  // Any outstanding memory access freezes the whole pipe.
  assign mem_wait = ~imem_resp | (dmem_req & ~dmem_resp);

  // Load-use: EX is loading a register that the ID instruction reads; r0 is not special.
  assign hazard = ex_is_load &
                  ((id_uses_sr1 & (id_sr1 == ex_dr)) |
                   (id_uses_sr2 & (id_sr2 == ex_dr)));

  // State register; reset returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // Next-state and stage-control decode, priority: reset > wait > branch > hazard.
  always_comb begin
    next_state   = RUN;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    nop_id_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_ex_mem = 1'b0;
    stall        = 1'b0;

    if (reset) begin
      // Load NOPs everywhere so in-flight instructions are discarded.
      nop_id_ex    = 1'b1;
      flush_if_id  = 1'b1;
      flush_ex_mem = 1'b1;
      stall        = 1'b1;
      next_state   = RUN;
    end else if (mem_wait) begin
      // Freeze; whatever was pending is re-evaluated once the wait ends.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      stall       = 1'b1;
      next_state  = state;
    end else if (mem_br_taken) begin
      // Redirect from MEM: squash IF, ID and EX; a coincident hazard is flushed too.
      nop_id_ex    = 1'b1;
      flush_if_id  = 1'b1;
      flush_ex_mem = 1'b1;
      stall        = 1'b1;
      next_state   = REDIRECT;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            // Hold PC and IF/ID, push one bubble into EX.
            load_pc    = 1'b0;
            load_if_id = 1'b0;
            nop_id_ex  = 1'b1;
            stall      = 1'b1;
            next_state = LU_BUBBLE;
          end
        end
        // One normal cycle; ID holds either the stalled consumer or a flushed NOP.
        LU_BUBBLE: next_state = RUN;
        REDIRECT:  next_state = RUN;
        default:   next_state = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic bump_stall;
  logic bump_bubble;
  logic bump_flush;

  assign bump_stall  = ~reset & mem_wait;
  assign bump_bubble = ~reset & ~mem_wait & (state == RUN) & (next_state == LU_BUBBLE);
  assign bump_flush  = ~reset & ~mem_wait & (next_state == REDIRECT);

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_bubbles   <= '0;
      perf_flushes   <= '0;
    end else begin
      if (bump_stall  && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (bump_bubble && (perf_bubbles   != '1)) perf_bubbles   <= perf_bubbles + 1'b1;
      if (bump_flush  && (perf_flushes   != '1)) perf_flushes   <= perf_flushes + 1'b1;
    end
  end
`else
  assign perf_stall_cyc = '0;
  assign perf_bubbles   = '0;
  assign perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed vectors for hazard_sequencer with hand-computed control words.
// Control word order: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, nop_id_ex, flush_if_id, flush_ex_mem, stall.
// Counter expectations collapse to zero when HAZARD_PERF_CNT_EN is undefined.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] W_RST    = 9'b11111_111_1;
  localparam logic [8:0] W_FLUSH  = 9'b11111_111_1;
  localparam logic [8:0] W_WAIT   = 9'b00000_000_1;
  localparam logic [8:0] W_BUBBLE = 9'b00111_100_1;
  localparam logic [8:0] W_NORM   = 9'b11111_000_0;

  logic             clk;
  logic             reset;
  logic [2:0]       id_sr1, id_sr2, ex_dr;
  logic             id_uses_sr1, id_uses_sr2, ex_is_load;
  logic             mem_br_taken, imem_resp, dmem_req, dmem_resp;
  logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             nop_id_ex, flush_if_id, flush_ex_mem, stall;
  logic [CNT_W-1:0] perf_stall_cyc, perf_bubbles, perf_flushes;
  logic [8:0]       ctl;

  int vectors = 0;
  int miscompares = 0;

  hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .ex_dr(ex_dr), .ex_is_load(ex_is_load),
    .mem_br_taken(mem_br_taken), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .nop_id_ex(nop_id_ex), .flush_if_id(flush_if_id), .flush_ex_mem(flush_ex_mem),
    .stall(stall),
    .perf_stall_cyc(perf_stall_cyc), .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                nop_id_ex, flush_if_id, flush_ex_mem, stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; sample the combinational word, then advance one cycle.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    id_sr1 = 3'd0; id_sr2 = 3'd0; ex_dr = 3'd7;
    id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0; ex_is_load = 1'b0;
    mem_br_taken = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  // LDR R3 in EX, ADD R1,R3,R2 in ID.
  task automatic hazard_sr1();
    id_sr1 = 3'd3; id_sr2 = 3'd2; ex_dr = 3'd3;
    id_uses_sr1 = 1'b1; id_uses_sr2 = 1'b1; ex_is_load = 1'b1;
  endtask

  task automatic check_cnt(input string tag, input int s, input int b, input int f);
    check({tag, ".stall_cyc"}, 32'(perf_stall_cyc), PERF ? 32'(s) : 32'd0);
    check({tag, ".bubbles"},   32'(perf_bubbles),   PERF ? 32'(b) : 32'd0);
    check({tag, ".flushes"},   32'(perf_flushes),   PERF ? 32'(f) : 32'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc("rst_a", W_RST);
    cyc("rst_b", W_RST);
    reset = 1'b0;
    check_cnt("after_rst", 0, 0, 0);
    cyc("run_idle", W_NORM);

    // Single load-use bubble on sr1; the bubble cycle ignores the still-visible hazard.
    hazard_sr1();
    cyc("lu_sr1", W_BUBBLE);
    cyc("lu_sr1_next", W_NORM);
    idle();
    cyc("lu_sr1_run", W_NORM);

    // sr2 match, and non-hazards: unused source, non-load producer.
    id_sr2 = 3'd5; ex_dr = 3'd5; id_uses_sr2 = 1'b1; ex_is_load = 1'b1;
    cyc("lu_sr2", W_BUBBLE);
    idle();
    cyc("lu_sr2_next", W_NORM);
    id_sr1 = 3'd4; ex_dr = 3'd4; id_uses_sr1 = 1'b0; ex_is_load = 1'b1;
    cyc("no_use_sr1", W_NORM);
    id_uses_sr1 = 1'b1; ex_is_load = 1'b0;
    cyc("not_load", W_NORM);

    // r0 is compared like any other register.
    idle();
    id_sr1 = 3'd0; ex_dr = 3'd0; id_uses_sr1 = 1'b1; ex_is_load = 1'b1;
    cyc("lu_r0", W_BUBBLE);
    idle();
    cyc("lu_r0_next", W_NORM);

    // Hazard under a 4-cycle data-memory wait: freeze, then exactly one bubble.
    hazard_sr1();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) cyc("dwait", W_WAIT);
    dmem_resp = 1'b1;
    cyc("dwait_bubble", W_BUBBLE);
    idle();
    cyc("dwait_run", W_NORM);

    // Branch and hazard together: flush wins, no bubble; REDIRECT suppresses detection.
    hazard_sr1();
    mem_br_taken = 1'b1;
    cyc("br_haz_flush", W_FLUSH);
    mem_br_taken = 1'b0;
    cyc("br_haz_redirect", W_NORM);
    idle();
    cyc("br_haz_run", W_NORM);

    // Branch held through a 3-cycle fetch wait.
    mem_br_taken = 1'b1; imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) cyc("iwait_br", W_WAIT);
    imem_resp = 1'b1;
    cyc("iwait_br_flush", W_FLUSH);
    mem_br_taken = 1'b0;
    hazard_sr1();
    cyc("iwait_redirect", W_NORM);
    idle();
    cyc("iwait_run", W_NORM);

    // Branch arriving in the bubble cycle takes precedence.
    hazard_sr1();
    cyc("lu_then_br", W_BUBBLE);
    mem_br_taken = 1'b1;
    cyc("lu_br_flush", W_FLUSH);
    mem_br_taken = 1'b0;
    cyc("lu_br_redirect", W_NORM);
    idle();
    cyc("lu_br_run", W_NORM);
    check_cnt("mid", 7, 5, 3);

    // 20 more wait cycles: stall counter saturates at 15 with CNT_W=4.
    imem_resp = 1'b0;
    for (int i = 0; i < 20; i++) cyc("long_wait", W_WAIT);
    idle();
    check_cnt("sat", 15, 5, 3);
    cyc("sat_run", W_NORM);

    // Reset mid-stream while sitting in LU_BUBBLE; must come back in RUN.
    hazard_sr1();
    cyc("pre_rst_bubble", W_BUBBLE);
    reset = 1'b1;
    cyc("mid_rst_a", W_RST);
    cyc("mid_rst_b", W_RST);
    reset = 1'b0;
    check_cnt("mid_rst", 0, 0, 0);
    cyc("post_rst_bubble", W_BUBBLE);
    idle();
    cyc("post_rst_run", W_NORM);
    check_cnt("end", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
